// File: rtl/usi_master_arbiter.sv
// -----------------------------------------------------------------------------
// usi_master_arbiter
//   Shares the single USI master port between pReqNum requesters. Requesters
//   are granted round-robin; each grant runs one bus transaction:
//     write : IDLE -> ISSUE (write strobe) -> DONE
//     read  : IDLE -> ISSUE (read strobe) -> RWAIT (wait for read-assert or
//             timeout) -> DONE
//   DONE pulses the one-hot ack (and err on a read timeout) for the granted
//   requester and advances the round-robin pointer past it.
//
// Ports
//   iSCLK, iSRST          clock, synchronous active-high reset
//   iReqVd/iReqCmd        per-requester valid / command (1 read, 0 write)
//   iReqAdrs/iReqWd       packed per-requester address / write data
//   oReqAck/oReqErr       one-hot completion / read-timeout pulses
//   oReqRd                read data, valid with the ack of a read
//   oMUsiWd/oMUsiAdrs     bus write data / address (held ISSUE..DONE)
//   oMUsiWEd/oMUsiRCmd    single-cycle bus write / read strobes
//   iMUsiRd/iMUsiREd      bus read data / slave read-assert lines
//   oBusy                 high in every state except IDLE
//   All outputs are registered.
// -----------------------------------------------------------------------------
module usi_master_arbiter #(
    parameter int pReqNum          = 2,
    parameter int pUsiBusWidth     = 16,
    parameter int pBusBlockConnect = 1,
    parameter int pTimeoutCycles   = 255
) (
    input  logic                              iSCLK,
    input  logic                              iSRST,
    input  logic [pReqNum-1:0]                iReqVd,
    input  logic [pReqNum-1:0]                iReqCmd,
    input  logic [pReqNum*pUsiBusWidth-1:0]   iReqAdrs,
    input  logic [pReqNum*32-1:0]             iReqWd,
    output logic [pReqNum-1:0]                oReqAck,
    output logic [pReqNum-1:0]                oReqErr,
    output logic [31:0]                       oReqRd,
    output logic [31:0]                       oMUsiWd,
    output logic [pUsiBusWidth-1:0]           oMUsiAdrs,
    output logic                              oMUsiWEd,
    output logic                              oMUsiRCmd,
    input  logic [31:0]                       iMUsiRd,
    input  logic [pBusBlockConnect-1:0]       iMUsiREd,
    output logic                              oBusy
);

    localparam int cIdxW  = (pReqNum > 1) ? $clog2(pReqNum) : 1;
    localparam int cIdxW1 = cIdxW + 1;
    // Counter value on the last permitted RWAIT cycle: RWAIT lasts at most
    // pTimeoutCycles cycles.
    localparam logic [15:0] cTmoLast = 16'(pTimeoutCycles - 1);
    localparam logic [cIdxW-1:0] cLastReq = cIdxW'(pReqNum - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RWAIT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One-hot decode of a requester index.
    function automatic logic [pReqNum-1:0] f_onehot(input logic [cIdxW-1:0] idx);
        logic [pReqNum-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t                    r_state,  w_state_nxt;
    logic [cIdxW-1:0]          r_ptr,    w_ptr_nxt;
    logic [cIdxW-1:0]          r_gnt,    w_gnt_nxt;
    logic                      r_cmd,    w_cmd_nxt;
    logic [pUsiBusWidth-1:0]   r_adrs,   w_adrs_nxt;
    logic [31:0]               r_wd,     w_wd_nxt;
    logic [15:0]               r_cnt,    w_cnt_nxt;
    logic                      r_err,    w_err_nxt;
    logic [31:0]               r_data,   w_data_nxt;

    logic [pReqNum-1:0]        r_ack,    w_ack_nxt;
    logic [pReqNum-1:0]        r_err_o,  w_err_o_nxt;
    logic [31:0]               r_rd_o,   w_rd_o_nxt;
    logic [31:0]               r_m_wd,   w_m_wd_nxt;
    logic [pUsiBusWidth-1:0]   r_m_adrs, w_m_adrs_nxt;
    logic                      r_wed,    w_wed_nxt;
    logic                      r_rcmd,   w_rcmd_nxt;
    logic                      r_busy,   w_busy_nxt;

    logic                      w_found;
    logic [cIdxW-1:0]          w_sel;
    logic [cIdxW1-1:0]         w_idx;
    logic [cIdxW-1:0]          w_cand;
    logic                      w_red_any;

    assign w_red_any = |iMUsiREd;

    // Round-robin search: first valid requester at or after the pointer, with wrap.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        w_cand  = '0;
        for (int i = 0; i < pReqNum; i++) begin
            w_idx = {1'b0, r_ptr} + cIdxW1'(i);
            if (w_idx >= cIdxW1'(pReqNum)) begin
                w_idx = w_idx - cIdxW1'(pReqNum);
            end else begin
                w_idx = w_idx;
            end
            w_cand = w_idx[cIdxW-1:0];
            if (!w_found && iReqVd[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Next-state and transaction-register logic.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_cmd_nxt   = r_cmd;
        w_adrs_nxt  = r_adrs;
        w_wd_nxt    = r_wd;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_data_nxt  = r_data;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt   = w_sel;
                    w_cmd_nxt   = iReqCmd[w_sel];
                    w_adrs_nxt  = iReqAdrs[int'(w_sel)*pUsiBusWidth +: pUsiBusWidth];
                    w_wd_nxt    = iReqWd[int'(w_sel)*32 +: 32];
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_cnt_nxt  = 16'd0;
                w_err_nxt  = 1'b0;
                w_data_nxt = 32'd0;
                if (r_cmd) begin
                    w_state_nxt = ST_RWAIT;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_RWAIT: begin
                // Read-assert has priority over a timeout in the same cycle.
                if (w_red_any) begin
                    w_data_nxt  = iMUsiRd;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == cTmoLast) begin
                    w_data_nxt  = 32'd0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt   = r_cnt + 16'd1;
                end
            end
            ST_DONE: begin
                if (r_gnt == cLastReq) begin
                    w_ptr_nxt = '0;
                end else begin
                    w_ptr_nxt = r_gnt + cIdxW'(1);
                end
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the
    // registered outputs line up with the state they belong to.
    always_comb begin
        w_wed_nxt    = 1'b0;
        w_rcmd_nxt   = 1'b0;
        w_busy_nxt   = 1'b0;
        w_m_adrs_nxt = '0;
        w_m_wd_nxt   = 32'd0;
        w_ack_nxt    = '0;
        w_err_o_nxt  = '0;
        w_rd_o_nxt   = 32'd0;
        if (w_state_nxt != ST_IDLE) begin
            w_busy_nxt   = 1'b1;
            w_m_adrs_nxt = w_adrs_nxt;
            w_m_wd_nxt   = w_wd_nxt;
        end else begin
            w_busy_nxt   = 1'b0;
        end
        if (w_state_nxt == ST_ISSUE) begin
            w_wed_nxt  = !w_cmd_nxt;
            w_rcmd_nxt = w_cmd_nxt;
        end else begin
            w_wed_nxt  = 1'b0;
        end
        if (w_state_nxt == ST_DONE) begin
            w_ack_nxt   = f_onehot(w_gnt_nxt);
            w_err_o_nxt = w_err_nxt ? f_onehot(w_gnt_nxt) : '0;
            w_rd_o_nxt  = w_data_nxt;
        end else begin
            w_ack_nxt   = '0;
        end
    end

    // State, transaction and output registers with synchronous reset.
    always_ff @(posedge iSCLK) begin
        if (iSRST) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_gnt    <= '0;
            r_cmd    <= 1'b0;
            r_adrs   <= '0;
            r_wd     <= 32'd0;
            r_cnt    <= 16'd0;
            r_err    <= 1'b0;
            r_data   <= 32'd0;
            r_ack    <= '0;
            r_err_o  <= '0;
            r_rd_o   <= 32'd0;
            r_m_wd   <= 32'd0;
            r_m_adrs <= '0;
            r_wed    <= 1'b0;
            r_rcmd   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_gnt    <= w_gnt_nxt;
            r_cmd    <= w_cmd_nxt;
            r_adrs   <= w_adrs_nxt;
            r_wd     <= w_wd_nxt;
            r_cnt    <= w_cnt_nxt;
            r_err    <= w_err_nxt;
            r_data   <= w_data_nxt;
            r_ack    <= w_ack_nxt;
            r_err_o  <= w_err_o_nxt;
            r_rd_o   <= w_rd_o_nxt;
            r_m_wd   <= w_m_wd_nxt;
            r_m_adrs <= w_m_adrs_nxt;
            r_wed    <= w_wed_nxt;
            r_rcmd   <= w_rcmd_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign oReqAck   = r_ack;
    assign oReqErr   = r_err_o;
    assign oReqRd    = r_rd_o;
    assign oMUsiWd   = r_m_wd;
    assign oMUsiAdrs = r_m_adrs;
    assign oMUsiWEd  = r_wed;
    assign oMUsiRCmd = r_rcmd;
    assign oBusy     = r_busy;

endmodule

// File: tb/tb_usi_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_usi_master_arbiter
//   Scoreboard bench: each transaction pushes its expected bus strobe and its
//   expected requester completion; negedge monitors pop and compare whenever
//   the arbiter produces a strobe or an ack. Directed checks cover reset
//   state, latency, round-robin order, timeout and reset mid-read.
// -----------------------------------------------------------------------------
module tb_usi_master_arbiter;

    localparam int W   = 16;
    localparam int TMO = 8;

    typedef struct {
        logic [1:0]  kind;   // {WEd, RCmd}
        logic [15:0] adrs;
        logic [31:0] wd;
    } bus_exp_t;

    typedef struct {
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] rd;
    } ack_exp_t;

    logic          clk;
    logic          srst;
    logic [1:0]    vd;
    logic [1:0]    cmd;
    logic [2*W-1:0] adrs;
    logic [63:0]   wd;
    logic [1:0]    ack;
    logic [1:0]    err;
    logic [31:0]   rd;
    logic [31:0]   m_wd;
    logic [W-1:0]  m_adrs;
    logic          m_wed;
    logic          m_rcmd;
    logic [31:0]   m_rd;
    logic [0:0]    m_red;
    logic          busy;

    int n_vec;
    int n_err;

    bus_exp_t q_bus[$];
    ack_exp_t q_ack[$];

    usi_master_arbiter #(
        .pReqNum(2), .pUsiBusWidth(W), .pBusBlockConnect(1), .pTimeoutCycles(TMO)
    ) dut (
        .iSCLK(clk), .iSRST(srst),
        .iReqVd(vd), .iReqCmd(cmd), .iReqAdrs(adrs), .iReqWd(wd),
        .oReqAck(ack), .oReqErr(err), .oReqRd(rd),
        .oMUsiWd(m_wd), .oMUsiAdrs(m_adrs), .oMUsiWEd(m_wed), .oMUsiRCmd(m_rcmd),
        .iMUsiRd(m_rd), .iMUsiREd(m_red), .oBusy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Edges from the drive point to the first visible ack; bounded.
    task automatic wait_ack(input string tag, input int exp_edges);
        int n;
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (ack != 2'b00) break;
        end
        chk_eq(tag, 64'(n), 64'(exp_edges));
    endtask

    // Bounded wait for the read strobe.
    task automatic wait_rcmd(input string tag);
        int n;
        n = 0;
        while (n < 20 && !m_rcmd) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_eq(tag, 64'(m_rcmd), 64'd1);
    endtask

    // Bus-side scoreboard: every strobe must match the oldest expected one.
    always @(negedge clk) begin
        if (!srst && (m_wed || m_rcmd)) begin
            if (q_bus.size() == 0) begin
                chk_eq("bus_unexpected", 64'({m_wed, m_rcmd}), 64'd0);
            end else begin
                bus_exp_t e;
                e = q_bus.pop_front();
                chk_eq("bus_kind", 64'({m_wed, m_rcmd}), 64'(e.kind));
                chk_eq("bus_adrs", 64'(m_adrs), 64'(e.adrs));
                chk_eq("bus_wd",   64'(m_wd),   64'(e.wd));
            end
        end
    end

    // Requester-side scoreboard: every ack must match the oldest expected one.
    always @(negedge clk) begin
        if (!srst && (ack != 2'b00)) begin
            if (q_ack.size() == 0) begin
                chk_eq("ack_unexpected", 64'(ack), 64'd0);
            end else begin
                ack_exp_t e;
                e = q_ack.pop_front();
                chk_eq("ack_onehot", 64'(ack), 64'(e.ack));
                chk_eq("ack_err",    64'(err), 64'(e.err));
                chk_eq("ack_rd",     64'(rd),  64'(e.rd));
            end
        end
    end

    initial begin
        n_vec  = 0;
        n_err  = 0;
        srst   = 1'b1;
        vd     = 2'b00;
        cmd    = 2'b00;
        adrs   = '0;
        wd     = 64'd0;
        m_rd   = 32'd0;
        m_red  = 1'b0;
        step(3);

        // Reset state
        chk_eq("rst_ack",  64'(ack), 64'd0);
        chk_eq("rst_busy", 64'(busy), 64'd0);
        chk_eq("rst_strb", 64'({m_wed, m_rcmd}), 64'd0);
        chk_eq("rst_adrs", 64'(m_adrs), 64'd0);
        chk_eq("rst_wd",   64'(m_wd), 64'd0);
        srst = 1'b0;
        step(1);

        // Requester 0 write; rise cycle, ISSUE, DONE -> ack two edges after drive
        q_bus.push_back('{kind: 2'b10, adrs: 16'h0104, wd: 32'hDEADBEEF});
        q_ack.push_back('{ack: 2'b01, err: 2'b00, rd: 32'd0});
        cmd  = 2'b00;
        adrs = {16'h0000, 16'h0104};
        wd   = {32'h0, 32'hDEADBEEF};
        vd   = 2'b01;
        wait_ack("wr0_latency", 2);
        vd = 2'b00;
        step(2);
        chk_eq("wr0_idle_busy", 64'(busy), 64'd0);

        // Requester 1 read; slave answers 4 cycles after the read strobe
        q_bus.push_back('{kind: 2'b01, adrs: 16'h0200, wd: 32'hA5A50000});
        q_ack.push_back('{ack: 2'b10, err: 2'b00, rd: 32'h12345678});
        cmd  = 2'b10;
        adrs = {16'h0200, 16'h0000};
        wd   = {32'hA5A50000, 32'h0};
        vd   = 2'b10;
        wait_rcmd("rd1_rcmd");
        step(3);
        chk_eq("rd1_busy_wait", 64'(busy), 64'd1);
        step(1);
        m_red = 1'b1;
        m_rd  = 32'h12345678;
        step(1);
        chk_eq("rd1_ack_next", 64'(ack), 64'b10);
        m_red = 1'b0;
        m_rd  = 32'd0;
        vd    = 2'b00;
        step(2);

        // Both requesters hold writes: grants alternate 0,1,0,1 every 3 cycles
        for (int k = 0; k < 2; k++) begin
            q_bus.push_back('{kind: 2'b10, adrs: 16'h0010, wd: 32'h11110000});
            q_ack.push_back('{ack: 2'b01, err: 2'b00, rd: 32'd0});
            q_bus.push_back('{kind: 2'b10, adrs: 16'h0020, wd: 32'h22220000});
            q_ack.push_back('{ack: 2'b10, err: 2'b00, rd: 32'd0});
        end
        cmd  = 2'b00;
        adrs = {16'h0020, 16'h0010};
        wd   = {32'h22220000, 32'h11110000};
        vd   = 2'b11;
        begin
            int acks, n, last;
            acks = 0;
            n    = 0;
            last = 0;
            while (acks < 4 && n < 60) begin
                @(posedge clk);
                #1;
                n++;
                if (ack != 2'b00) begin
                    acks++;
                    if (acks > 1) chk_eq("b2b_gap", 64'(n - last), 64'd3);
                    last = n;
                    if (acks == 4) vd = 2'b00;
                end
            end
            chk_eq("b2b_count", 64'(acks), 64'd4);
        end
        step(2);

        // Requester 0 read with no slave answer: timeout after TMO wait cycles
        q_bus.push_back('{kind: 2'b01, adrs: 16'h0300, wd: 32'h33330000});
        q_ack.push_back('{ack: 2'b01, err: 2'b01, rd: 32'd0});
        cmd  = 2'b01;
        adrs = {16'h0000, 16'h0300};
        wd   = {32'h0, 32'h33330000};
        m_rd = 32'hFFFFFFFF;
        vd   = 2'b01;
        wait_ack("tmo_latency", 2 + TMO);
        chk_eq("tmo_err_with_ack", 64'(err), 64'(ack));
        vd = 2'b00;
        step(1);
        m_red = 1'b1;
        step(1);
        m_red = 1'b0;
        step(2);
        chk_eq("tmo_late_red_busy", 64'(busy), 64'd0);
        chk_eq("tmo_late_red_ack",  64'(ack), 64'd0);
        m_rd = 32'd0;

        // Reset during RWAIT, late read-assert ignored, then pointer back at 0
        q_bus.push_back('{kind: 2'b01, adrs: 16'h0400, wd: 32'h44440000});
        cmd  = 2'b10;
        adrs = {16'h0400, 16'h0000};
        wd   = {32'h44440000, 32'h0};
        vd   = 2'b10;
        wait_rcmd("rst_rd_rcmd");
        step(2);
        srst = 1'b1;
        vd   = 2'b00;
        step(1);
        srst = 1'b0;
        chk_eq("midrst_busy", 64'(busy), 64'd0);
        chk_eq("midrst_adrs", 64'(m_adrs), 64'd0);
        m_red = 1'b1;
        m_rd  = 32'hCAFEF00D;
        step(2);
        m_red = 1'b0;
        chk_eq("midrst_no_ack",  64'(ack), 64'd0);
        chk_eq("midrst_idle",    64'(busy), 64'd0);

        q_bus.push_back('{kind: 2'b10, adrs: 16'h0500, wd: 32'h55550000});
        q_ack.push_back('{ack: 2'b01, err: 2'b00, rd: 32'd0});
        cmd  = 2'b00;
        adrs = {16'h0600, 16'h0500};
        wd   = {32'h66660000, 32'h55550000};
        vd   = 2'b11;
        wait_ack("post_rst_latency", 2);
        vd = 2'b00;
        step(4);

        chk_eq("q_bus_drained", 64'(q_bus.size()), 64'd0);
        chk_eq("q_ack_drained", 64'(q_ack.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
